// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: write port, two read ports, clear control,
// status and FSM state visibility.
//
// Protocol: a write is taken at the rising edge where we=1 and clr_busy=0.
// It is discarded while clr_busy=1. A clear request is taken at the rising
// edge where clr_req=1 and the clear FSM is idle. It is ignored while a sweep
// or its done cycle is in progress. Read data is combinational from raddr1/2.
interface reg_file_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic [ADDR_W-1:0]        raddr1;
    logic [ADDR_W-1:0]        raddr2;
    logic [DATA_W-1:0]        rdata1;
    logic [DATA_W-1:0]        rdata2;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;
    logic [(2**ADDR_W)-1:0]   dirty;
    logic [1:0]               clr_state;  // 0=IDLE, 1=SWEEP, 2=DONE

    modport master (
        output we, waddr, wdata, raddr1, raddr2, clr_req,
        input  rdata1, rdata2, clr_busy, clr_done, dirty, clr_state
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, clr_req,
        output rdata1, rdata2, clr_busy, clr_done, dirty, clr_state
    );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file with two combinational read ports, one write
// port, optional hardwired-zero register 0, optional write-to-read
// forwarding, per-entry dirty bits and a sequential clear sweep.
module reg_file_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input logic clk,
    input logic rst_n,
    reg_file_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    clr_state_t         state_q;
    clr_state_t         state_d;
    logic [ADDR_W-1:0]  ptr_q;
    logic [DATA_W-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0]   dirty_q;
    logic               wr_acc;
    logic               ptr_last;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;

    // A write lands only outside the sweep; register 0 is read-only when
    // hardwired to zero, so such writes also leave dirty[0] alone.
    assign wr_acc   = bus.we && (state_q != SWEEP) &&
                      !((ZERO_R0 != 0) && (bus.waddr == '0));
    assign ptr_last = (ptr_q == ADDR_W'(DEPTH - 1));

    // Register array: async zero, sweep clears one entry per cycle, else write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (state_q == SWEEP) begin
            regs_q[ptr_q] <= '0;
        end else if (wr_acc) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

    // Dirty bits follow the same accept/sweep rules as the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_q <= '0;
        end else if (state_q == SWEEP) begin
            dirty_q[ptr_q] <= 1'b0;
        end else if (wr_acc) begin
            dirty_q[bus.waddr] <= 1'b1;
        end
    end

    // Sweep pointer: restarts at 0 on each accepted request, stops at DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (state_q == IDLE && bus.clr_req) begin
            ptr_q <= '0;
        end else if (state_q == SWEEP) begin
            ptr_q <= ptr_last ? '0 : ptr_q + 1'b1;
        end
    end

    // Clear FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Clear FSM next state; requests outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.clr_req) state_d = SWEEP;
            SWEEP:   if (ptr_last)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read ports: array lookup, optional same-cycle forwarding, r0 forced to 0.
    always_comb begin
        rd1 = regs_q[bus.raddr1];
        rd2 = regs_q[bus.raddr2];
        if ((BYPASS != 0) && wr_acc && (bus.waddr == bus.raddr1)) rd1 = bus.wdata;
        if ((BYPASS != 0) && wr_acc && (bus.waddr == bus.raddr2)) rd2 = bus.wdata;
        if ((ZERO_R0 != 0) && (bus.raddr1 == '0)) rd1 = '0;
        if ((ZERO_R0 != 0) && (bus.raddr2 == '0)) rd2 = '0;
    end

    assign bus.rdata1    = rd1;
    assign bus.rdata2    = rd2;
    assign bus.clr_busy  = (state_q == SWEEP);
    assign bus.clr_done  = (state_q == DONE);
    assign bus.dirty     = dirty_q;
    assign bus.clr_state = state_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: four instances cover the default build,
// BYPASS=0, ZERO_R0=1 and a 16-bit x 16-entry build.
module tb_reg_file_param;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    reg_file_param_if #(.DATA_W(8),  .ADDR_W(3)) if_d ();
    reg_file_param_if #(.DATA_W(8),  .ADDR_W(3)) if_n ();
    reg_file_param_if #(.DATA_W(8),  .ADDR_W(3)) if_z ();
    reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) if_w ();

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(0), .BYPASS(1))
        u_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));
    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(0), .BYPASS(0))
        u_n (.clk(clk), .rst_n(rst_n), .bus(if_n.slave));
    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1), .BYPASS(1))
        u_z (.clk(clk), .rst_n(rst_n), .bus(if_z.slave));
    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(1))
        u_w (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;
        int bad;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        if_d.we = 0; if_d.waddr = '0; if_d.wdata = '0; if_d.raddr1 = '0; if_d.raddr2 = '0; if_d.clr_req = 0;
        if_n.we = 0; if_n.waddr = '0; if_n.wdata = '0; if_n.raddr1 = '0; if_n.raddr2 = '0; if_n.clr_req = 0;
        if_z.we = 0; if_z.waddr = '0; if_z.wdata = '0; if_z.raddr1 = '0; if_z.raddr2 = '0; if_z.clr_req = 0;
        if_w.we = 0; if_w.waddr = '0; if_w.wdata = '0; if_w.raddr1 = '0; if_w.raddr2 = '0; if_w.clr_req = 0;

        // Reset takes effect before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rdata1", if_d.rdata1, 8'h00);
        chk("rst_dirty", if_d.dirty, 8'h00);
        chk("rst_busy", if_d.clr_busy, 1'b0);
        chk("rst_done", if_d.clr_done, 1'b0);
        chk("rst_state", if_d.clr_state, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_dirty", if_d.dirty, 8'h00);

        // Basic write then read on the following cycle
        if_d.we = 1; if_d.waddr = 3'd3; if_d.wdata = 8'hA5;
        tick();
        if_d.we = 0; if_d.raddr1 = 3'd3;
        #1;
        chk("wr3_rdata1", if_d.rdata1, 8'hA5);
        chk("wr3_dirty", if_d.dirty, 8'h08);

        // Forwarding vs no forwarding, same-cycle view
        if_d.we = 1; if_d.waddr = 3'd5; if_d.wdata = 8'h3C; if_d.raddr2 = 3'd5;
        if_n.we = 1; if_n.waddr = 3'd5; if_n.wdata = 8'h3C; if_n.raddr2 = 3'd5;
        #1;
        chk("byp_rdata2", if_d.rdata2, 8'h3C);
        chk("byp_port1_indep", if_d.rdata1, 8'hA5);
        chk("nobyp_rdata2_old", if_n.rdata2, 8'h00);
        tick();
        if_d.we = 0; if_n.we = 0;
        #1;
        chk("byp_after_edge", if_d.rdata2, 8'h3C);
        chk("nobyp_after_edge", if_n.rdata2, 8'h3C);
        chk("dirty_3_5", if_d.dirty, 8'h28);

        // Hardwired register 0
        if_z.we = 1; if_z.waddr = 3'd0; if_z.wdata = 8'hFF; if_z.raddr1 = 3'd0;
        #1;
        chk("z0_no_fwd", if_z.rdata1, 8'h00);
        tick();
        if_z.we = 1; if_z.waddr = 3'd1; if_z.wdata = 8'h11; if_z.raddr2 = 3'd1;
        #1;
        chk("z0_after_edge", if_z.rdata1, 8'h00);
        chk("z0_dirty0", if_z.dirty, 8'h00);
        chk("z1_fwd", if_z.rdata2, 8'h11);
        tick();
        if_z.we = 0;
        #1;
        chk("z1_dirty", if_z.dirty, 8'h02);

        // Fill all registers, then sweep
        for (int i = 0; i < 8; i++) begin
            if_d.we = 1; if_d.waddr = 3'(i); if_d.wdata = 8'(8'h10 + i);
            tick();
        end
        if_d.we = 0; if_d.raddr1 = 3'd7;
        #1;
        chk("fill_r7", if_d.rdata1, 8'h17);
        chk("fill_dirty", if_d.dirty, 8'hFF);
        if_d.clr_req = 1;
        tick();
        // cycle n+1; keep clr_req high and try to write during the sweep
        if_d.we = 1; if_d.waddr = 3'd7; if_d.wdata = 8'hEE;
        if_d.raddr1 = 3'd2; if_d.raddr2 = 3'd5;
        #1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("sweep_busy_%0d", k), if_d.clr_busy, 1'b1);
            chk($sformatf("sweep_nodone_%0d", k), if_d.clr_done, 1'b0);
            if (k == 1) chk("sweep_k1_r2_old", if_d.rdata1, 8'h12);
            if (k == 4) begin
                chk("sweep_k4_r2_zero", if_d.rdata1, 8'h00);
                chk("sweep_k4_r5_old", if_d.rdata2, 8'h15);
            end
            tick();
        end
        // cycle n+9
        if_d.we = 0;
        #1;
        chk("sweep_done", if_d.clr_done, 1'b1);
        chk("sweep_done_notbusy", if_d.clr_busy, 1'b0);
        chk("sweep_dirty", if_d.dirty, 8'h00);
        for (int a = 0; a < 4; a++) begin
            if_d.raddr1 = 3'(a); if_d.raddr2 = 3'(a + 4);
            #1;
            chk($sformatf("sweep_zero_r%0d", a), if_d.rdata1, 8'h00);
            chk($sformatf("sweep_zero_r%0d", a + 4), if_d.rdata2, 8'h00);
        end
        tick();
        if_d.clr_req = 0;
        #1;
        chk("after_done_busy", if_d.clr_busy, 1'b0);
        chk("after_done_done", if_d.clr_done, 1'b0);
        chk("after_done_state", if_d.clr_state, 2'd0);

        // Reset in the middle of a sweep
        if_d.we = 1; if_d.waddr = 3'd6; if_d.wdata = 8'h66;
        tick();
        if_d.we = 0; if_d.clr_req = 1;
        tick();
        if_d.clr_req = 0;
        tick();
        tick();
        tick();
        if_d.raddr1 = 3'd6;
        #1;
        chk("midsweep_r6_old", if_d.rdata1, 8'h66);
        chk("midsweep_busy", if_d.clr_busy, 1'b1);
        chk("midsweep_dirty", if_d.dirty, 8'h40);
        rst_n = 1'b0;
        #1;
        chk("abort_r6", if_d.rdata1, 8'h00);
        chk("abort_busy", if_d.clr_busy, 1'b0);
        chk("abort_done", if_d.clr_done, 1'b0);
        chk("abort_dirty", if_d.dirty, 8'h00);
        chk("abort_state", if_d.clr_state, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (if_d.clr_done !== 1'b0 || if_d.clr_busy !== 1'b0) bad++;
        end
        chk("abort_no_done", bad, 0);

        // Wide build: 16-bit data, 16 entries
        if_w.we = 1; if_w.waddr = 4'd15; if_w.wdata = 16'hBEEF;
        tick();
        if_w.we = 0; if_w.raddr1 = 4'd15;
        #1;
        chk("wide_r15", if_w.rdata1, 16'hBEEF);
        chk("wide_dirty", if_w.dirty, 16'h8000);
        if_w.clr_req = 1;
        tick();
        if_w.clr_req = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int c = 0; c < 40; c++) begin
            if (if_w.clr_busy === 1'b1) busy_cnt++;
            if (if_w.clr_done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            tick();
        end
        chk("wide_busy_cycles", busy_cnt, 16);
        chk("wide_done_count", done_cnt, 1);
        chk("wide_done_at", done_at, 16);
        chk("wide_r15_cleared", if_w.rdata1, 16'h0000);
        chk("wide_dirty_cleared", if_w.dirty, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
